// File: rtl/idma_init_gen.sv
// INIT-protocol pattern source: queues requests and returns one generated beat per request.
// Supports constant fill, incrementing bytes and a 32-bit LFSR stream with persistent state.
module idma_init_gen #(
   parameter int unsigned StrbWidth      = 16,
   parameter int unsigned NumOutstanding = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [1:0]             req_mode_i,
   input  logic                   req_restart_i,
   input  logic [31:0]            req_value_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [8*StrbWidth-1:0] rsp_init_o,
   output logic                   busy_o
);

   localparam int unsigned DataW    = 8 * StrbWidth;
   localparam int unsigned NumWords = StrbWidth / 4;
   localparam int unsigned PtrW     = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
   localparam int unsigned CntW     = $clog2(NumOutstanding + 1);
   localparam logic [31:0] LfsrTaps = 32'h8020_0003;

   typedef enum logic [1:0] {
      ModeConst = 2'd0,
      ModeIncr  = 2'd1,
      ModeLfsr  = 2'd2,
      ModeZero  = 2'd3
   } mode_e;

   typedef struct packed {
      mode_e       mode;
      logic        restart;
      logic [31:0] value;
   } req_t;

   req_t             fifo_mem [NumOutstanding];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [CntW-1:0]  count;
   logic             fifo_empty;
   logic             fifo_full;

   req_t             in_req;
   req_t             head;
   logic             accept;
   logic             have_head;
   logic             out_free;
   logic             pop;
   logic             pop_fifo;
   logic             push_fifo;

   logic [31:0]      state;
   logic [31:0]      eff;
   logic [31:0]      lfsr;
   logic [31:0]      next_state;
   logic [DataW-1:0] gen_data;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? LfsrTaps : 32'h0);
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(NumOutstanding - 1)) return '0;
      return p + 1'b1;
   endfunction

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // valid never waits on ready, and once raised valid/data hold until accepted.
   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == CntW'(NumOutstanding));
   assign req_ready_o = !fifo_full;
   assign accept      = req_valid_i & req_ready_o;
   assign busy_o      = !fifo_empty | rsp_valid_o;

   always_comb begin
      in_req         = '0;
      in_req.mode    = mode_e'(req_mode_i);
      in_req.restart = req_restart_i;
      in_req.value   = req_value_i;
   end

   // Fall-through: with an empty FIFO the incoming request is the head.
   assign head      = fifo_empty ? in_req : fifo_mem[rd_ptr];
   assign have_head = !fifo_empty | accept;
   assign out_free  = !rsp_valid_o | rsp_ready_i;
   assign pop       = have_head & out_free;
   assign pop_fifo  = pop & !fifo_empty;
   assign push_fifo = accept & !(fifo_empty & pop);

   always_ff @(posedge clk_i) begin
      if (push_fifo) fifo_mem[wr_ptr] <= in_req;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fifo) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_fifo)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CntW'(push_fifo) - CntW'(pop_fifo);
      end
   end

   always_comb begin
      gen_data   = '0;
      next_state = state;
      lfsr       = '0;
      eff        = head.restart ? head.value : state;
      unique case (head.mode)
         ModeConst: begin
            for (int i = 0; i < int'(StrbWidth); i++) gen_data[8*i +: 8] = head.value[7:0];
         end
         ModeIncr: begin
            for (int i = 0; i < int'(StrbWidth); i++) gen_data[8*i +: 8] = eff[7:0] + 8'(i);
            next_state = eff + 32'(StrbWidth);
         end
         ModeLfsr: begin
            // An all-zero seed would lock the LFSR, so it is nudged to 1.
            lfsr = (eff == '0) ? 32'd1 : eff;
            for (int k = 0; k < int'(NumWords); k++) begin
               lfsr = lfsr_step(lfsr);
               gen_data[32*k +: 32] = lfsr;
            end
            next_state = lfsr;
         end
         ModeZero: begin
            gen_data = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_o <= 1'b0;
         rsp_init_o  <= '0;
         state       <= '0;
      end else if (pop) begin
         rsp_valid_o <= 1'b1;
         rsp_init_o  <= gen_data;
         state       <= next_state;
      end else if (rsp_ready_i) begin
         rsp_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_idma_init_gen.sv
// Self-checking bench for idma_init_gen: directed pattern checks plus a scoreboard
// fed from an independent pattern model at request acceptance.
module tb_idma_init_gen;

   localparam int W = 128;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_mode;
   logic         req_restart;
   logic [31:0]  req_value;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_init;
   logic         busy;

   logic [W-1:0] exp_q[$];
   logic [31:0]  s_model;
   int           n_checks;
   int           n_pass;
   logic         prev_stall;
   logic [W-1:0] prev_data;
   logic         rnd_done;

   idma_init_gen #(.StrbWidth(16), .NumOutstanding(2)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_mode_i   (req_mode),
      .req_restart_i(req_restart),
      .req_value_i  (req_value),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_init_o   (rsp_init),
      .busy_o       (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic model_beat(input logic [1:0] m, input logic r, input logic [31:0] v,
                             output logic [W-1:0] beat);
      logic [31:0] e;
      logic [31:0] x;
      beat = '0;
      e = r ? v : s_model;
      case (m)
         2'd0: for (int i = 0; i < 16; i++) beat[8*i +: 8] = v[7:0];
         2'd1: begin
            for (int i = 0; i < 16; i++) beat[8*i +: 8] = e[7:0] + 8'(i);
            s_model = e + 32'd16;
         end
         2'd2: begin
            x = (e == 32'd0) ? 32'd1 : e;
            for (int k = 0; k < 4; k++) begin
               x = {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
               beat[32*k +: 32] = x;
            end
            s_model = x;
         end
         default: ;
      endcase
   endtask

   // scoreboard: push on request handshake, pop on response handshake, watch stalls
   always @(negedge clk) begin
      logic [W-1:0] beat;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", W'(rsp_valid), W'(1));
            check("hold_data", rsp_init, prev_data);
         end
         if (req_valid && req_ready) begin
            model_beat(req_mode, req_restart, req_value, beat);
            exp_q.push_back(beat);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected_beat", W'(rsp_valid), W'(0));
            else check("sb_beat", rsp_init, exp_q.pop_front());
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_data  = rsp_init;
      end
   end

   // driver tasks
   task automatic send_req(input logic [1:0] m, input logic r, input logic [31:0] v);
      int waited = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_mode = m; req_restart = r; req_value = v;
      @(negedge clk);
      while (!req_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!req_ready) check("req_accept_timeout", W'(req_ready), W'(1));
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_after_drain", W'(busy), W'(0));
   endtask

   initial begin
      n_checks = 0; n_pass = 0; s_model = '0; prev_stall = 1'b0; prev_data = '0;
      rnd_done = 1'b0;
      rst_n = 1'b0; req_valid = 1'b0; req_mode = '0; req_restart = 1'b0; req_value = '0;
      rsp_ready = 1'b1;

      #12;
      check("rst_valid", W'(rsp_valid), W'(0));
      check("rst_data", rsp_init, W'(0));
      check("rst_ready", W'(req_ready), W'(1));
      check("rst_busy", W'(busy), W'(0));
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("idle_valid", W'(rsp_valid), W'(0));
         check("idle_ready", W'(req_ready), W'(1));
         check("idle_busy", W'(busy), W'(0));
      end

      // constant fill, one cycle latency, state untouched
      send_req(2'd0, 1'b0, 32'h0000_00A5);
      @(negedge clk);
      check("const_latency", W'(rsp_valid), W'(1));
      check("const_data", rsp_init, {16{8'hA5}});
      send_req(2'd1, 1'b0, 32'h0);
      @(negedge clk);
      check("const_state_kept", rsp_init, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

      // incrementing with byte wrap
      send_req(2'd1, 1'b1, 32'h0000_00F8);
      @(negedge clk);
      check("incr_wrap_beat1", rsp_init, 128'h07060504_03020100_FFFEFDFC_FBFAF9F8);
      send_req(2'd1, 1'b0, 32'h0);
      @(negedge clk);
      check("incr_wrap_beat2", rsp_init, 128'h17161514_13121110_0F0E0D0C_0B0A0908);

      // reserved mode gives zero and leaves state alone
      send_req(2'd3, 1'b1, 32'hFFFF_FFFF);
      @(negedge clk);
      check("mode3_zero", rsp_init, W'(0));
      send_req(2'd1, 1'b0, 32'h0);

      // LFSR zero seed
      send_req(2'd2, 1'b1, 32'h0);
      @(negedge clk);
      check("lfsr_zero_seed", rsp_init, 128'hB02C0003_60180001_C0300002_80200003);
      send_req(2'd2, 1'b0, 32'h0);
      send_req(2'd0, 1'b1, 32'h0);
      send_req(2'd2, 1'b0, 32'h0);
      wait_idle();

      // backpressure: three accepted, fourth held off until the FIFO drains
      rsp_ready = 1'b0;
      send_req(2'd1, 1'b1, 32'h40);
      send_req(2'd1, 1'b0, 32'h0);
      send_req(2'd1, 1'b0, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b1; req_mode = 2'd0; req_restart = 1'b0; req_value = 32'h3C;
      repeat (3) begin
         @(negedge clk);
         check("full_ready_low", W'(req_ready), W'(0));
         check("full_busy", W'(busy), W'(1));
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      check("drain0_valid", W'(rsp_valid), W'(1));
      @(negedge clk);
      check("drain1_valid", W'(rsp_valid), W'(1));
      check("fourth_ready", W'(req_ready), W'(1));
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      check("drain2_valid", W'(rsp_valid), W'(1));
      wait_idle();

      // random traffic with random response backpressure
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               send_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      rsp_ready = 1'b1;
      wait_idle();

      // reset with beats queued
      rsp_ready = 1'b0;
      send_req(2'd2, 1'b1, 32'h1234_5678);
      send_req(2'd1, 1'b0, 32'h0);
      send_req(2'd0, 1'b0, 32'h77);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      exp_q.delete();
      s_model = '0;
      check("midrst_valid", W'(rsp_valid), W'(0));
      check("midrst_data", rsp_init, W'(0));
      check("midrst_ready", W'(req_ready), W'(1));
      check("midrst_busy", W'(busy), W'(0));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      rsp_ready = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("post_rst_no_beat", W'(rsp_valid), W'(0));
      end
      send_req(2'd1, 1'b0, 32'h0);
      @(negedge clk);
      check("post_rst_state", rsp_init, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      wait_idle();

      check("sb_leftover", W'(exp_q.size()), W'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
